// File: rtl/scram_pkg.sv
// Shared types and lab permutation tables for the scrambling register file.
// Latency: none (declarations only).
// Backpressure: not applicable.
package scram_pkg;

    typedef enum logic [1:0] {
        MODE_REV  = 2'b00,
        MODE_ROL  = 2'b01,
        MODE_SCR  = 2'b10,
        MODE_DSCR = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        WR   = 2'b10,
        FIN  = 2'b11
    } state_e;

    // Output bit n of a scrambled byte comes from input bit LAB_PERM[n].
    localparam logic [7:0][2:0] LAB_PERM = {3'd0, 3'd7, 3'd1, 3'd6, 3'd2, 3'd5, 3'd3, 3'd4};
    // Inverse table: LAB_INV[LAB_PERM[n]] == n.
    localparam logic [7:0][2:0] LAB_INV  = {3'd6, 3'd4, 3'd2, 3'd0, 3'd1, 3'd3, 3'd5, 3'd7};

endpackage

// File: rtl/scram_reg_file_if.sv
// Host port and sweep control bundle; CHECKSUM exists only with SCRAM_CHECKSUM_EN.
// Latency: none (wires only).
// Backpressure: BUSY tells the host its accesses are being ignored.
interface scram_reg_file_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
);
    localparam int ADDR_W = $clog2(DEPTH);

    logic              CS;
    logic              WS;
    logic              OE;
    logic [ADDR_W-1:0] ADDR;
    logic [WIDTH-1:0]  DIN;
    logic [WIDTH-1:0]  DOUT;
    logic              START;
    logic [1:0]        MODE;
    logic              BUSY;
    logic              DONE;
`ifdef SCRAM_CHECKSUM_EN
    logic [WIDTH-1:0]  CHECKSUM;
`endif

    modport master (
        output CS, WS, OE, ADDR, DIN, START, MODE,
`ifdef SCRAM_CHECKSUM_EN
        input  CHECKSUM,
`endif
        input  DOUT, BUSY, DONE
    );

    modport slave (
        input  CS, WS, OE, ADDR, DIN, START, MODE,
`ifdef SCRAM_CHECKSUM_EN
        output CHECKSUM,
`endif
        output DOUT, BUSY, DONE
    );
endinterface

// File: rtl/scram_lane.sv
// One byte lane of the lab scramble (inv=0) or descramble (inv=1) permutation.
// Latency: combinational.
// Backpressure: none.
module scram_lane
    import scram_pkg::*;
(
    input  logic [7:0] lane_dat,
    input  logic       inv,
    output logic [7:0] perm_dat
);

    // Gather each output bit from the source bit named by the selected table.
    always_comb begin
        perm_dat = '0;
        for (int n = 0; n < 8; n++) begin
            perm_dat[n] = inv ? lane_dat[LAB_INV[n]] : lane_dat[LAB_PERM[n]];
        end
    end

endmodule

// File: rtl/scram_reg_file.sv
// Register file with an in-place permutation sweep engine; SCRAM_CHECKSUM_EN adds a CHECKSUM of pre-sweep words.
// Latency: reads 1 cycle; a sweep takes 2*DEPTH+1 cycles (RD/WR per word, then FIN).
// Backpressure: host accesses are dropped while BUSY; START is ignored outside IDLE.
module scram_reg_file
    import scram_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32
) (
    input  logic             CLK,
    input  logic             RST_N,
    scram_reg_file_if.slave  bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int LANES  = WIDTH / 8;

    logic [WIDTH-1:0]  mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    mode_e             mode_q, mode_d;
    logic [WIDTH-1:0]  dout_q, dout_d;
    logic [WIDTH-1:0]  csum_q, csum_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [WIDTH-1:0]  mem_wdat;
    logic [WIDTH-1:0]  lab_dat;
    logic [WIDTH-1:0]  perm_dat;
    logic              addr_ok;

    // Non-power-of-two depths leave holes at the top of the address space.
    assign addr_ok = (32'(bus.ADDR) < 32'(DEPTH));

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        scram_lane u_lane (
            .lane_dat (hold_q[8*g +: 8]),
            .inv      (mode_q == MODE_DSCR),
            .perm_dat (lab_dat[8*g +: 8])
        );
    end

    // Select the permutation latched at sweep start.
    always_comb begin
        perm_dat = lab_dat;
        case (mode_q)
            MODE_REV: for (int i = 0; i < WIDTH; i++) perm_dat[i] = hold_q[WIDTH-1-i];
            MODE_ROL: perm_dat = {hold_q[WIDTH-2:0], hold_q[WIDTH-1]};
            default:  perm_dat = lab_dat;
        endcase
    end

    // Next-state logic: host port in IDLE, read/write-back walk otherwise.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        mode_d    = mode_q;
        dout_d    = dout_q;
        csum_d    = csum_q;
        mem_we    = 1'b0;
        mem_waddr = ptr_q;
        mem_wdat  = perm_dat;
        case (state_q)
            IDLE: begin
                if (bus.CS && bus.WS) begin
                    if (addr_ok) begin
                        mem_we    = 1'b1;
                        mem_waddr = bus.ADDR;
                        mem_wdat  = bus.DIN;
                    end
                end else if (bus.CS && bus.OE) begin
                    dout_d = addr_ok ? mem_q[bus.ADDR] : '0;
                end
                // A same-cycle host write lands before the first RD sees memory.
                if (bus.START) begin
                    state_d = RD;
                    mode_d  = mode_e'(bus.MODE);
                    ptr_d   = '0;
                    csum_d  = '0;
                end
            end
            RD: begin
                hold_d  = mem_q[ptr_q];
`ifdef SCRAM_CHECKSUM_EN
                csum_d  = csum_q ^ mem_q[ptr_q];
`endif
                state_d = WR;
            end
            WR: begin
                mem_we = 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = FIN;
                end else begin
                    ptr_d   = ptr_q + 1'b1;
                    state_d = RD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            hold_q  <= '0;
            mode_q  <= MODE_REV;
            dout_q  <= '0;
            csum_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
            dout_q  <= dout_d;
            csum_q  <= csum_d;
        end
    end

    // Storage is not reset; a write in the reset cycle is dropped so an aborted sweep leaves no half-step.
    always_ff @(posedge CLK) begin
        if (RST_N && mem_we) begin
            mem_q[mem_waddr] <= mem_wdat;
        end
    end

    assign bus.DOUT = dout_q;
    assign bus.BUSY = (state_q != IDLE);
    assign bus.DONE = (state_q == FIN);
`ifdef SCRAM_CHECKSUM_EN
    assign bus.CHECKSUM = csum_q;
`endif

endmodule

// File: tb/tb_scram_reg_file.sv
// Randomized bench for scram_reg_file against a sweep-level behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_scram_reg_file;

    localparam int W  = 8;
    localparam int D  = 32;
    localparam int AW = $clog2(D);

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    scram_reg_file_if #(.WIDTH(W), .DEPTH(D)) bus ();
    scram_reg_file #(.WIDTH(W), .DEPTH(D)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;
    int done_cnt = 0;
    bit chk_en = 1'b0;

    // Reference model state.
    logic [W-1:0] mdl [D];
    bit           m_sweep;
    int           m_cnt;
    logic [1:0]   m_mode;
    logic [W-1:0] e_dout, e_csum;
    bit           e_busy, e_done;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Permutation as written in the datasheet, one output bit at a time.
    function automatic logic [W-1:0] bperm(input logic [W-1:0] x, input logic [1:0] m);
        int scr[8] = '{4, 3, 5, 2, 6, 1, 7, 0};
        logic [W-1:0] o;
        o = '0;
        case (m)
            2'b00: for (int i = 0; i < W; i++) o[i] = x[W-1-i];
            2'b01: o = (x << 1) | (x >> (W-1));
            2'b10: for (int b = 0; b < W/8; b++) for (int n = 0; n < 8; n++) o[8*b+n] = x[8*b+scr[n]];
            default: for (int b = 0; b < W/8; b++) for (int n = 0; n < 8; n++) o[8*b+scr[n]] = x[8*b+n];
        endcase
        return o;
    endfunction

    // Model: a sweep is a counter over 2*D+1 cycles; word k is rewritten at the end of cycle 2k+1.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_sweep = 0; m_cnt = 0; e_dout = '0; e_csum = '0;
        end else if (!m_sweep) begin
            if (bus.CS && bus.WS) begin
                if (int'(bus.ADDR) < D) mdl[bus.ADDR] = bus.DIN;
            end else if (bus.CS && bus.OE) begin
                e_dout = (int'(bus.ADDR) < D) ? mdl[bus.ADDR] : '0;
            end
            if (bus.START) begin
                m_sweep = 1; m_cnt = 0; m_mode = bus.MODE;
                e_csum = '0;
                for (int k = 0; k < D; k++) e_csum = e_csum ^ mdl[k];
            end
        end else begin
            if (m_cnt % 2 == 1) mdl[m_cnt/2] = bperm(mdl[m_cnt/2], m_mode);
            if (m_cnt == 2*D) m_sweep = 0;
            else m_cnt++;
        end
        e_busy = m_sweep;
        e_done = m_sweep && (m_cnt == 2*D);
    end

    // Cycle-by-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("dout", bus.DOUT, e_dout);
            check("busy", bus.BUSY, e_busy);
            check("done", bus.DONE, e_done);
`ifdef SCRAM_CHECKSUM_EN
            if (!e_busy || e_done) check("csum", bus.CHECKSUM, e_csum);
`endif
        end
        if (bus.DONE === 1'b1) done_cnt++;
    end

    task automatic host_write(input int a, input logic [W-1:0] d);
        bus.CS = 1; bus.WS = 1; bus.OE = 0; bus.ADDR = AW'(a); bus.DIN = d;
        @(negedge clk);
        bus.CS = 0; bus.WS = 0;
    endtask

    task automatic host_read(input int a, output logic [W-1:0] d);
        bus.CS = 1; bus.WS = 0; bus.OE = 1; bus.ADDR = AW'(a);
        @(negedge clk);
        bus.CS = 0; bus.OE = 0;
        d = bus.DOUT;
    endtask

    task automatic do_sweep(input logic [1:0] m, input bit inject, output int cyc, output bit done_seen);
        bus.START = 1; bus.MODE = m;
        @(negedge clk);
        bus.START = 0; bus.MODE = ~m;
        cyc = 0; done_seen = 0;
        while (bus.BUSY === 1'b1 && cyc < 300) begin
            if (bus.DONE === 1'b1) done_seen = 1;
            if (inject) begin
                bus.CS    = (cyc == 10) || (cyc == 12);
                bus.WS    = (cyc == 10);
                bus.OE    = (cyc == 12);
                bus.ADDR  = (cyc == 10) ? AW'(3) : AW'(7);
                bus.DIN   = 8'h5A;
                bus.START = (cyc == 14);
            end
            cyc++;
            @(negedge clk);
        end
        bus.CS = 0; bus.WS = 0; bus.OE = 0; bus.START = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] d, keep, o3;
        logic [W-1:0] orig [D];
        int  cyc, dc0;
        bit  ds;

        rst_n = 0;
        bus.CS = 0; bus.WS = 0; bus.OE = 0; bus.ADDR = '0; bus.DIN = '0;
        bus.START = 0; bus.MODE = 2'b00;
        repeat (3) @(negedge clk);
        chk_en = 1;
        check("rst_dout", bus.DOUT, 8'h00);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_done", bus.DONE, 1'b0);
`ifdef SCRAM_CHECKSUM_EN
        check("rst_csum", bus.CHECKSUM, 8'h00);
`endif
        rst_n = 1;
        @(negedge clk);

        host_write(3, 8'h01);
        host_read(3, d);
        check("rd_a3", d, 8'h01);

        // Fill, then the 0xA5 scramble example with sweep length.
        for (int a = 0; a < D; a++) host_write(a, W'($urandom));
        host_write(0, 8'hA5);
        do_sweep(2'b10, 0, cyc, ds);
        check("sweep_len", cyc, 2*D+1);
        check("done_seen", ds, 1'b1);
        host_read(0, d);
        check("a5_scr", d, 8'hCC);

        // Scramble then descramble restores a random fill.
        for (int a = 0; a < D; a++) begin orig[a] = W'($urandom); host_write(a, orig[a]); end
        do_sweep(2'b10, 0, cyc, ds);
        do_sweep(2'b11, 0, cyc, ds);
        for (int a = 0; a < D; a++) begin host_read(a, d); check("roundtrip", d, orig[a]); end

        host_write(1, 8'h81);
        do_sweep(2'b01, 0, cyc, ds);
        host_read(1, d);
        check("rol_81", d, 8'h03);
        host_write(2, 8'h01);
        do_sweep(2'b00, 0, cyc, ds);
        host_read(2, d);
        check("rev_01", d, 8'h80);

        // Host access and START during BUSY are ignored.
        host_read(3, o3);
        keep = bus.DOUT;
        do_sweep(2'b10, 1, cyc, ds);
        check("busy_len", cyc, 2*D+1);
        check("busy_dout", bus.DOUT, keep);
        host_read(3, d);
        check("busy_wr", d, bperm(o3, 2'b10));

        // Reset while word 10 is being read.
        for (int a = 0; a < D; a++) begin orig[a] = W'($urandom); host_write(a, orig[a]); end
        dc0 = done_cnt;
        bus.START = 1; bus.MODE = 2'b10;
        @(negedge clk);
        bus.START = 0;
        repeat (20) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        repeat (3) @(negedge clk);
        check("rst_nodone", done_cnt, dc0);
        check("rst_idle", bus.BUSY, 1'b0);
        for (int a = 0; a < D; a++) begin
            host_read(a, d);
            check("rst_words", d, (a < 10) ? bperm(orig[a], 2'b10) : orig[a]);
        end

`ifdef SCRAM_CHECKSUM_EN
        for (int a = 0; a < D; a++) host_write(a, W'(a));
        do_sweep(2'b00, 0, cyc, ds);
        check("csum_idx", bus.CHECKSUM, 8'h00);
        for (int a = 0; a < D; a++) host_write(a, W'(a));
        host_write(5, 8'hFF);
        do_sweep(2'b01, 0, cyc, ds);
        check("csum_ff", bus.CHECKSUM, 8'hFA);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
